// File: rtl/parity_frame_checker_if.sv
// ---------------------------------------------------------------------------
// parity_frame_checker_if
// Bundles the serial receive input and the decoded-word output of the parity
// frame checker.
//   bit_en     : bit-sample strobe (master -> checker)
//   rx_bit     : serial line, idles high (master -> checker)
//   data_out   : last completed frame's data word (checker -> master)
//   out_valid  : one-clk pulse, frame complete (checker -> master)
//   parity_err : last frame's parity bit disagreed with its data (checker -> master)
//   frame_err  : last frame's stop bit sampled low (checker -> master)
//   busy       : a frame is in progress (checker -> master)
//   err_count  : saturating count of errored frames (checker -> master)
// ---------------------------------------------------------------------------
interface parity_frame_checker_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
);
  logic              bit_en;
  logic              rx_bit;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output bit_en, rx_bit,
    input  data_out, out_valid, parity_err, frame_err, busy, err_count
  );

  modport slave (
    input  bit_en, rx_bit,
    output data_out, out_valid, parity_err, frame_err, busy, err_count
  );
endinterface

// File: rtl/parity_frame_checker.sv
// ---------------------------------------------------------------------------
// parity_frame_checker
// Receive side of the even-parity serial link. Deserialises frames of
// start(0), DATA_W data bits LSB first, parity, stop(1); checks the parity bit
// against the XOR of the data bits and reports each completed word with
// parity and framing error flags. The line is only sampled on bit_en.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : parity_frame_checker_if.slave (bit_en/rx_bit in; data_out,
//           out_valid, parity_err, frame_err, busy, err_count out)
//
// Optional feature macro: PARITY_ERR_CNT_EN
//   defined   : err_count counts errored frames, saturating at 2^CNT_W-1
//   undefined : no counter logic, err_count tied to zero
// ---------------------------------------------------------------------------
module parity_frame_checker #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  parity_frame_checker_if.slave bus
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shift;
  logic              run_par;
  logic              mismatch;

  logic start_frame;
  logic store_bit;
  logic capture_par;
  logic finish_frame;

  // Even parity accumulates as a running XOR of every data bit seen.
  function automatic logic par_step(input logic par, input logic b);
    return par ^ b;
  endfunction

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; the machine only advances on a sample strobe.
  always_comb begin
    state_next = state;
    if (bus.bit_en) begin
      case (state)
        IDLE: begin
          if (!bus.rx_bit) state_next = DATA;
          else             state_next = IDLE;
        end
        DATA: begin
          if (idx == LAST_IDX) state_next = PARITY;
          else                 state_next = DATA;
        end
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end else begin
      state_next = state;
    end
  end

  // FSM output decode: one action strobe per sampled bit.
  always_comb begin
    start_frame  = 1'b0;
    store_bit    = 1'b0;
    capture_par  = 1'b0;
    finish_frame = 1'b0;
    if (bus.bit_en) begin
      case (state)
        IDLE:    start_frame  = ~bus.rx_bit;
        DATA:    store_bit    = 1'b1;
        PARITY:  capture_par  = 1'b1;
        STOP:    finish_frame = 1'b1;
        default: start_frame  = 1'b0;
      endcase
    end else begin
      start_frame = 1'b0;
    end
  end

  // Deserialiser: bit index, shift register, running parity, parity verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= {IDX_W{1'b0}};
      shift    <= {DATA_W{1'b0}};
      run_par  <= 1'b0;
      mismatch <= 1'b0;
    end else if (start_frame) begin
      idx     <= {IDX_W{1'b0}};
      shift   <= {DATA_W{1'b0}};
      run_par <= 1'b0;
    end else if (store_bit) begin
      shift[idx] <= bus.rx_bit;
      run_par    <= par_step(run_par, bus.rx_bit);
      idx        <= idx + IDX_W'(1);
    end else if (capture_par) begin
      // Folding the parity bit into the data XOR leaves 1 on a mismatch.
      mismatch <= par_step(run_par, bus.rx_bit);
    end
  end

  // Registered result outputs; data and flags hold until the next frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_out   <= {DATA_W{1'b0}};
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.out_valid <= finish_frame;
      bus.busy      <= (state_next != IDLE);
      if (finish_frame) begin
        bus.data_out   <= shift;
        bus.parity_err <= mismatch;
        bus.frame_err  <= ~bus.rx_bit;
      end
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;

  // Saturating errored-frame counter; a frame counts once even with both flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= {CNT_W{1'b0}};
    end else if (finish_frame && (mismatch || !bus.rx_bit) && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign bus.err_count = err_cnt;
`else
  assign bus.err_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_checker
// Self-checking bench for parity_frame_checker. A reference model derives the
// expected word, flags and error count from the frame contents with plain
// arithmetic; a monitor captures every out_valid pulse into a queue.
// ---------------------------------------------------------------------------
module tb_parity_frame_checker;

  localparam int DATA_W  = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              perr;
    logic              ferr;
    logic [CNT_W-1:0]  cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   clk_run = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [DATA_W-1:0] exp_data = '0;
  logic              exp_perr = 1'b0;
  logic              exp_ferr = 1'b0;
  int                err_frames = 0;

  obs_t obs_q[$];

  parity_frame_checker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  parity_frame_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 if (clk_run) clk = ~clk;

  // Record every cycle in which out_valid is high.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1)
      obs_q.push_back('{data: bus.data_out, perr: bus.parity_err,
                        ferr: bus.frame_err, cnt: bus.err_count});
  end

  function automatic logic ref_parity(input logic [DATA_W-1:0] w);
    int ones = 0;
    for (int i = 0; i < DATA_W; i++) ones += int'(w[i]);
    return (ones % 2) == 1;
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef PARITY_ERR_CNT_EN
    if (err_frames > CNT_MAX) return CNT_W'(CNT_MAX);
    return CNT_W'(err_frames);
`else
    return '0;
`endif
  endfunction

  function automatic void model_frame(input logic [DATA_W-1:0] w, input logic p, input logic s);
    exp_data = w;
    exp_perr = (ref_parity(w) != p);
    exp_ferr = ~s;
    if (exp_perr || exp_ferr) err_frames++;
  endfunction

  function automatic void model_reset();
    exp_data = '0; exp_perr = 1'b0; exp_ferr = 1'b0; err_frames = 0;
  endfunction

  task automatic send_bit(input logic b, input int gap);
    bus.bit_en = 1'b1;
    bus.rx_bit = b;
    @(posedge clk); #1;
    bus.bit_en = 1'b0;
    bus.rx_bit = 1'b1;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Drives one whole frame; with rnd set each gap is random in 0..gap.
  task automatic send_frame(input logic [DATA_W-1:0] w, input logic p, input logic s,
                            input int gap, input bit rnd);
    logic [DATA_W+1:0] bits;
    bits = {p, w, 1'b0};
    for (int i = 0; i < DATA_W + 2; i++)
      send_bit(bits[i], rnd ? int'($urandom_range(gap, 0)) : gap);
    send_bit(s, 0);
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] w;
    repeat (3) @(posedge clk); #1;
    vectors++;
    if ({bus.data_out, bus.out_valid, bus.parity_err, bus.frame_err, bus.busy, bus.err_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h v=%b pe=%b fe=%b busy=%b cnt=%0d, want all 0",
               bus.data_out, bus.out_valid, bus.parity_err, bus.frame_err, bus.busy, bus.err_count);
    end
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    // a frame so data_out is non-zero, then a partial frame, then reset with the clock stopped
    w = 4'b1101;
    send_frame(w, ref_parity(w), 1'b1, 0, 1'b0);
    model_frame(w, ref_parity(w), 1'b1);
    @(negedge clk); #1;
    vectors++;
    if (obs_q.size() != 1 || obs_q[0].data !== exp_data) begin
      miscompares++;
      $display("FAIL reset_preframe: got %0d pulses data=%h, want 1 pulse data=%h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 4'h0, exp_data);
    end
    obs_q.delete();
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    clk_run = 1'b0;
    #20;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.data_out, bus.out_valid, bus.parity_err, bus.frame_err, bus.busy, bus.err_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_noclk: got data=%h v=%b pe=%b fe=%b busy=%b cnt=%0d, want all 0",
               bus.data_out, bus.out_valid, bus.parity_err, bus.frame_err, bus.busy, bus.err_count);
    end
    model_reset();
    #5 rst_n = 1'b1;
    clk_run = 1'b1;
    repeat (2) @(posedge clk); #1;
  endtask

  typedef struct {
    logic [DATA_W-1:0] w;
    logic              p;
    logic              s;
    int                gap;
  } frame_t;

  task automatic test_directed();
    frame_t tbl[5];
    obs_t   o;
    tbl[0] = '{4'b1011, 1'b1, 1'b1, 0};   // clean word
    tbl[1] = '{4'b0110, 1'b1, 1'b1, 0};   // parity error
    tbl[2] = '{4'b1111, 1'b0, 1'b0, 0};   // break at stop
    tbl[3] = '{4'b0001, 1'b1, 1'b1, 0};   // back-to-back clean word
    tbl[4] = '{4'b1011, 1'b1, 1'b1, 3};   // clean word with 3-cycle gaps
    for (int k = 0; k < 5; k++) begin
      send_frame(tbl[k].w, tbl[k].p, tbl[k].s, tbl[k].gap, 1'b0);
      model_frame(tbl[k].w, tbl[k].p, tbl[k].s);
      @(negedge clk); #1;
      vectors++;
      if (obs_q.size() != 1) begin
        miscompares++;
        $display("FAIL directed_pulses[%0d]: got %0d out_valid cycles, want 1", k, obs_q.size());
      end
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        vectors++;
        if (o !== '{exp_data, exp_perr, exp_ferr, exp_cnt()}) begin
          miscompares++;
          $display("FAIL directed_result[%0d]: got data=%b pe=%b fe=%b cnt=%0d, want data=%b pe=%b fe=%b cnt=%0d",
                   k, o.data, o.perr, o.ferr, o.cnt, exp_data, exp_perr, exp_ferr, exp_cnt());
        end
      end
      obs_q.delete();
      vectors++;
      if (bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL directed_busy[%0d]: got %b, want 0", k, bus.busy);
      end
    end
    repeat (4) begin @(posedge clk); #1; end
    vectors++;
    if (obs_q.size() != 0 || bus.out_valid !== 1'b0 ||
        {bus.data_out, bus.parity_err, bus.frame_err} !== {exp_data, exp_perr, exp_ferr}) begin
      miscompares++;
      $display("FAIL directed_hold: got pulses=%0d v=%b data=%b pe=%b fe=%b, want 0 0 %b %b %b",
               obs_q.size(), bus.out_valid, bus.data_out, bus.parity_err, bus.frame_err,
               exp_data, exp_perr, exp_ferr);
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [DATA_W-1:0] w;
    obs_t o;
    send_bit(1'b0, 1);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_busy: got %b, want 1", bus.busy);
    end
    bus.bit_en = 1'b1;              // data bit 2 on the line when reset hits
    bus.rx_bit = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({bus.data_out, bus.out_valid, bus.parity_err, bus.frame_err, bus.busy, bus.err_count} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got data=%h v=%b pe=%b fe=%b busy=%b cnt=%0d, want all 0",
               bus.data_out, bus.out_valid, bus.parity_err, bus.frame_err, bus.busy, bus.err_count);
    end
    bus.bit_en = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL midreset_no_valid: got %0d out_valid cycles, want 0", obs_q.size());
    end
    obs_q.delete();
    w = 4'b1010;
    send_frame(w, ref_parity(w), 1'b1, 0, 1'b0);
    model_frame(w, ref_parity(w), 1'b1);
    @(negedge clk); #1;
    vectors++;
    if (obs_q.size() != 1) begin
      miscompares++;
      $display("FAIL midreset_pulses: got %0d, want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      vectors++;
      if (o !== '{exp_data, exp_perr, exp_ferr, exp_cnt()}) begin
        miscompares++;
        $display("FAIL midreset_result: got data=%b pe=%b fe=%b cnt=%0d, want data=%b pe=%b fe=%b cnt=%0d",
                 o.data, o.perr, o.ferr, o.cnt, exp_data, exp_perr, exp_ferr, exp_cnt());
      end
    end
    obs_q.delete();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] w;
    logic p, s;
    obs_t o;
    for (int k = 0; k < 60; k++) begin
      w = DATA_W'($urandom);
      p = ref_parity(w) ^ ($urandom_range(3, 0) == 0);
      s = ($urandom_range(4, 0) != 0);
      send_frame(w, p, s, 2, 1'b1);
      model_frame(w, p, s);
      @(negedge clk); #1;
      vectors++;
      if (obs_q.size() != 1) begin
        miscompares++;
        $display("FAIL random_pulses[%0d]: got %0d, want 1", k, obs_q.size());
      end else begin
        o = obs_q.pop_front();
        vectors++;
        if (o !== '{exp_data, exp_perr, exp_ferr, exp_cnt()}) begin
          miscompares++;
          $display("FAIL random_result[%0d]: got data=%b pe=%b fe=%b cnt=%0d, want data=%b pe=%b fe=%b cnt=%0d",
                   k, o.data, o.perr, o.ferr, o.cnt, exp_data, exp_perr, exp_ferr, exp_cnt());
        end
      end
      obs_q.delete();
      if ($urandom_range(1, 0) == 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_saturation();
    logic [DATA_W-1:0] w;
    obs_t o;
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 260; k++) begin
      w = DATA_W'($urandom);
      send_frame(w, ~ref_parity(w), 1'b1, 0, 1'b0);
      model_frame(w, ~ref_parity(w), 1'b1);
      @(negedge clk); #1;
      vectors++;
      if (obs_q.size() != 1) begin
        miscompares++;
        $display("FAIL sat_pulses[%0d]: got %0d, want 1", k, obs_q.size());
      end else begin
        o = obs_q.pop_front();
        vectors++;
        if (o.cnt !== exp_cnt() || o.perr !== 1'b1) begin
          miscompares++;
          $display("FAIL sat_count[%0d]: got cnt=%0d pe=%b, want cnt=%0d pe=1", k, o.cnt, o.perr, exp_cnt());
        end
      end
      obs_q.delete();
    end
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
`ifdef PARITY_ERR_CNT_EN
    if (bus.err_count !== CNT_W'(CNT_MAX)) begin
      miscompares++;
      $display("FAIL sat_final: got %0d, want %0d", bus.err_count, CNT_MAX);
    end
`else
    if (bus.err_count !== '0) begin
      miscompares++;
      $display("FAIL sat_final: got %0d, want 0", bus.err_count);
    end
`endif
  endtask

  initial begin
    bus.bit_en = 1'b0;
    bus.rx_bit = 1'b1;
    test_reset();
    test_directed();
    test_reset_mid_frame();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
